// File: rtl/sequence_playback_pkg.sv
// Shared widths and playback FSM encodings for the move-sequence game blocks.
package seq_pkg;
  localparam int MOVE_W  = 4;
  localparam int ADDR_W  = 5;
  localparam int LEVEL_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_e;

  // Move memory holds eight moves at the bottom of a 32-entry space.
  function automatic logic [ADDR_W-1:0] move_addr(input logic [LEVEL_W-1:0] idx);
    return {{(ADDR_W-LEVEL_W){1'b0}}, idx};
  endfunction
endpackage

// File: rtl/sequence_playback_if.sv
// Move memory read port shared by the playback block and the memory.
interface sequence_playback_if;
  import seq_pkg::*;

  // Read port protocol: no valid/ready; the memory returns qR for the address
  // presented in the previous cycle, so the reader waits exactly one cycle.
  logic [ADDR_W-1:0] addressR;
  logic [MOVE_W-1:0] qR;

  modport master (output addressR, input qR);
  modport slave  (input addressR, output qR);
endinterface

// File: rtl/sequence_playback_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module playback_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             en,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = loadValue;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/sequence_playback.sv
// Replays moves 0..level from the move memory on the LEDs, each lit for
// ON_CYCLES then dark for OFF_CYCLES, and pulses done after the last one.
module sequence_playback
  import seq_pkg::*;
#(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int CNT_W      = 26
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [LEVEL_W-1:0]  level,
  sequence_playback_if.master mem,
  output logic [MOVE_W-1:0]   leds,
  output logic                busy,
  output logic                done,
  output state_e              dbg_state
);
  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] move_idx_q, move_idx_d;
  logic [LEVEL_W-1:0] last_idx_q, last_idx_d;
  logic [MOVE_W-1:0]  move_reg_q, move_reg_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_en;
  logic             tmr_zero;

  playback_timer #(.CNT_W(CNT_W)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (tmr_load),
    .loadValue (tmr_value),
    .en        (tmr_en),
    .zero      (tmr_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      move_idx_q <= '0;
      last_idx_q <= '0;
      move_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      move_idx_q <= move_idx_d;
      last_idx_q <= last_idx_d;
      move_reg_q <= move_reg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    move_idx_d = move_idx_q;
    last_idx_d = last_idx_q;
    move_reg_d = move_reg_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          last_idx_d = level;
          move_idx_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // Memory data for the FETCH address is valid now.
        move_reg_d = mem.qR;
        tmr_load   = 1'b1;
        tmr_value  = CNT_W'(ON_CYCLES - 1);
        state_d    = S_SHOW;
      end
      S_SHOW: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(OFF_CYCLES - 1);
          state_d   = S_GAP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          if (move_idx_q < last_idx_q) begin
            move_idx_d = move_idx_q + LEVEL_W'(1);
            state_d    = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.addressR = move_addr(move_idx_q);
  assign leds         = (state_q == S_SHOW) ? move_reg_q : '0;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_sequence_playback.sv
// Directed bench for sequence_playback with a one-cycle-latency move memory.
module tb_sequence_playback;
  import seq_pkg::*;

  localparam int ON    = 3;
  localparam int OFF   = 2;
  localparam int CW    = 4;
  localparam int PER   = 2 + ON + OFF;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   level;
  logic [3:0]   leds;
  logic         busy;
  logic         done;
  state_e       dbg_state;
  logic [3:0]   mem [8];

  int n_checks = 0;
  int n_err    = 0;

  sequence_playback_if mem_bus ();

  sequence_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .level     (level),
    .mem       (mem_bus.master),
    .leds      (leds),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // move memory: registered read
  always @(posedge clock) mem_bus.qR <= mem[mem_bus.addressR[2:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for cycle c of a playback of moves 0..lvl.
  typedef struct {
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [4:0] addr;
  } exp_t;

  function automatic exp_t model(input int c, input int lvl);
    exp_t e;
    int   done_c, k, p;
    done_c = 1 + (lvl + 1) * PER;
    e.leds = 4'd0;
    e.busy = (c >= 1) && (c <= done_c);
    e.done = (c == done_c);
    k = (c >= 1) ? (c - 1) / PER : 0;
    p = (c >= 1) ? (c - 1) % PER : 0;
    if (c >= 1 && c < done_c && p >= 2 && p < 2 + ON) e.leds = mem[k];
    e.addr = 5'((k > lvl) ? lvl : k);
    return e;
  endfunction

  // driver + per-cycle scoreboard; start is sampled at the edge ending cycle 0
  task automatic run(input int lvl, input int ncyc, input bit poke,
                     input int exp_done, input string name);
    exp_t e;
    int   first_done;
    first_done = -1;
    @(posedge clock); #1;
    start = 1'b1;
    level = 3'(lvl);
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        start = 1'b0;
        if (poke && (c == 4 || c == 10)) begin
          start = 1'b1;
          level = 3'd7;
        end
      end
      e = model(c, lvl);
      check($sformatf("%s leds c%0d", name, c), 32'(leds), 32'(e.leds));
      check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(e.busy));
      check($sformatf("%s done c%0d", name, c), 32'(done), 32'(e.done));
      if (c > 0) check($sformatf("%s addr c%0d", name, c), 32'(mem_bus.addressR), 32'(e.addr));
      if (done && first_done < 0) first_done = c;
    end
    start = 1'b0;
    if (exp_done >= 0) check($sformatf("%s done_cycle", name), 32'(first_done), 32'(exp_done));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    level = 3'd0;
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
    mem[4] = 4'b0001; mem[5] = 4'b0010; mem[6] = 4'b0100; mem[7] = 4'b1000;

    repeat (3) @(posedge clock);
    #1;
    check("rst leds",  32'(leds), 32'd0);
    check("rst busy",  32'(busy), 32'd0);
    check("rst done",  32'(done), 32'd0);
    check("rst addr",  32'(mem_bus.addressR), 32'd0);
    check("rst state", 32'(dbg_state), 32'(S_IDLE));
    reset = 1'b1;

    run(0, 11, 1'b0, 8,  "lvl0");
    run(2, 25, 1'b0, 22, "lvl2");
    run(7, 60, 1'b0, 57, "lvl7");
    run(1, 18, 1'b1, 15, "poke");

    mem[1] = 4'b0000;
    run(1, 18, 1'b0, 15, "q0");
    mem[1] = 4'b0010;

    // abort a level-3 playback while move 1 is lit (cycle 12)
    run(3, 13, 1'b0, -1, "abort");
    #2;
    reset = 1'b0;
    #1;
    check("abort leds", 32'(leds), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort addr", 32'(mem_bus.addressR), 32'd0);
    check("abort state", 32'(dbg_state), 32'(S_IDLE));
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check($sformatf("abort done %0d", i), 32'(done), 32'd0);
      check($sformatf("abort busy %0d", i), 32'(busy), 32'd0);
    end
    #3;
    reset = 1'b1;
    run(1, 18, 1'b0, 15, "replay");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/sequence_playback.md
# sequence_playback

Plays a stored level back to the player. After the level generator has written moves 0..level into the move memory as 4-bit one-hot words, this block reads them back in order and shows each on the four LEDs for a fixed on-time, followed by a dark gap. It pulses `done` when the last move has been shown. It sits between the move memory read port and the LED outputs, and the game controller starts it once level generation reports done.

## Interface
Parameters:
- `ON_CYCLES`, default 25_000_000: cycles each move stays lit; must be ≥1.
- `OFF_CYCLES`, default 12_500_000: dark cycles after each move; must be ≥1.
- `CNT_W`, default 26: timer width; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `start`  in  1  one-cycle request to begin playback; sampled only in S_IDLE.
- `level`  in  3  index of the last move, 0..7; latched when `start` is accepted.
- `addressR`  out  5  move memory read address, {2'b00, moveIdx}.
- `qR`  in  4  move memory read data; valid one cycle after `addressR` is presented.
- `leds`  out  4  one-hot move currently shown; 0 when dark.
- `busy`  out  1  high in every state except S_IDLE.
- `done`  out  1  one-cycle pulse when playback completes.

## Operation
- Registers: `state`, `moveIdx[2:0]`, `lastIdx[2:0]`, `moveReg[3:0]`, and the timer count.
- States: S_IDLE, S_FETCH, S_CAPTURE, S_SHOW, S_GAP, S_DONE.
- S_IDLE: with `start`=1, latch `lastIdx`←`level`, clear `moveIdx`←0, and go to S_FETCH. Otherwise stay in S_IDLE.
- S_FETCH: `addressR` presents `moveIdx`. Go to S_CAPTURE.
- S_CAPTURE: `moveReg`←`qR`; load the timer with ON_CYCLES−1; go to S_SHOW.
- S_SHOW: `leds`=`moveReg`. When the timer is 0, load it with OFF_CYCLES−1 and go to S_GAP. Otherwise decrement the timer.
- S_GAP: `leds`=0. When the timer is 0:
  - if `moveIdx` < `lastIdx`, increment `moveIdx` and go to S_FETCH;
  - otherwise go to S_DONE.
  - If the timer is not 0, decrement it.
- S_DONE: `done`=1 for exactly one cycle, then go to S_IDLE.
- `qR` is displayed verbatim, including non-one-hot values. The block does not check data.
- `start` outside S_IDLE is ignored. Changes to `level` after acceptance have no effect.
- `moveIdx` never wraps: its maximum value is `lastIdx` ≤ 7.
- `addressR` always equals {2'b00, `moveIdx`}; it is not gated by state.
- `leds`, `busy` and `done` are decoded combinationally from registered state and `moveReg` only; no input-to-output paths.

## Timing
- Reset values: state=S_IDLE, `moveIdx`=0, `lastIdx`=0, `moveReg`=0, timer=0. Outputs: `addressR`=0, `leds`=0, `busy`=0, `done`=0.
- Reset asserted mid-playback: `leds` and `busy` drop immediately (asynchronously). No `done` pulse is produced.
- Per move: 2 + ON_CYCLES + OFF_CYCLES cycles. The read latency of 1 is absorbed by S_CAPTURE.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in S_IDLE.
- S_FETCH occupies cycle 1.
- The first lit cycle is cycle 3.
- `done` is high in cycle 1 + (level+1)·(2+ON_CYCLES+OFF_CYCLES).
- A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `seq_pkg`: state encodings, `MOVE_W`=4, `ADDR_W`=5, `LEVEL_W`=3. The generator and the input checker use the same widths.
- One sub-module, `playback_timer`:
  - inputs: `load`, `loadValue[CNT_W-1:0]`, `en`;
  - output: `zero`;
  - down-counter with the same clock and reset as the parent.
- FSM and datapath live in the top module.

## Test plan
- Memory {0001,0010,0100,1000,…}, ON=3, OFF=2, level=0:
  - `leds`=0001 in cycles 3–5 and 0 in cycles 6–7;
  - `done` pulses in cycle 8;
  - `addressR` stays 0 throughout.
- Same memory, level=2:
  - `leds` shows 0001, 0010, 0100, each for 3 cycles, starting at cycles 3, 10 and 17;
  - `done` pulses in cycle 22;
  - `busy` is high in cycles 1–22.
- level=7 with all eight addresses loaded:
  - `addressR` steps 0..7 and does not wrap;
  - `done` pulses in cycle 57.
- `start` pulsed in cycles 4 and 10 of a level=1 playback:
  - both pulses are ignored;
  - timing is identical to an undisturbed run.
- `reset` driven low in cycle 12 of a level=3 playback:
  - `leds`=0, `busy`=0 and `addressR`=0 immediately;
  - no `done` pulse;
  - a fresh `start` then replays from address 0.
- `qR`=0000 at address 1 during a level=1 playback: `leds` stays 0 for that move's on-time; the sequence continues normally.
